input_sram_reader: RTL and testbench
====================================

Name: input_sram_reader

Overview:
- Read-side controller for the ping-pong input SRAM block (8 banks, 128 rows x 128 bits, two halves A/B).
- On a start command it sweeps a row window across all 8 banks in parallel and streams each 8x128-bit row to the PE array over a valid/ready interface.
- It owns ping_pong_select: it flips the select after each completed pass and returns the drained half to the loader.

Parameters:
- NUM_BANKS, 8, banks read in parallel per row.
- DATA_W, 128, bank word width.
- ADDR_W, 7, bank row address width (128 rows).
- FIFO_DEPTH, 2, output buffer entries; fixed at 2 (skid for 1-cycle SRAM latency).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle command pulse; accepted only in IDLE.
- base_addr  input  ADDR_W  first row of the window; sampled on accepted start.
- row_count  input  ADDR_W+1  rows to read, 0..128; sampled on accepted start.
- half_loaded  input  1  level from loader: the half currently selected by ping_pong_select holds valid data.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when a pass completes.
- half_release  output  1  one-cycle pulse, coincident with done; loader may refill the drained half.
- ping_pong_select  output  1  half selector to the SRAM block.
- sram_A  output  [ADDR_W-1:0] x NUM_BANKS  row address, identical across banks.
- sram_CEN  output  1 x NUM_BANKS  chip enable, active-low.
- sram_OEN  output  1 x NUM_BANKS  output enable, active-low.
- sram_WEN  output  1 x NUM_BANKS  write enable, active-low; held 1 (read only).
- sram_DI  output  [DATA_W-1:0] x NUM_BANKS  held 0.
- sram_DO  input  [DATA_W-1:0] x NUM_BANKS  bank read data; valid the cycle after a CEN-low edge.
- out_data  output  [DATA_W-1:0] x NUM_BANKS  row data, bank i on lane i.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the row when out_valid && out_ready.

Behaviour:
- Reset values (any cycle, including mid-pass):
  - busy=0, done=0, half_release=0, out_valid=0, ping_pong_select=0.
  - sram_CEN=1, sram_OEN=1, sram_WEN=1, sram_A=0, sram_DI=0.
  - Row counters=0; FIFO and in-flight flag cleared.
  - Any partial pass is aborted with no done pulse.
- States: IDLE, WAIT_BUF, READ, DRAIN, FINISH.
- IDLE:
  - start with row_count!=0: latch base_addr and row_count, busy=1, go to WAIT_BUF.
  - start with row_count==0: done and half_release pulse next cycle, ping_pong_select unchanged, stay IDLE.
  - start while not in IDLE is ignored.
- WAIT_BUF: go to READ when half_loaded=1; CEN stays 1.
- READ, issue rule:
  - Issue when issued<row_count and (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready in the same cycle.
  - An issue drives sram_CEN=0 on all banks with sram_A = (base_addr + issued) mod 128; address wrap past 127 goes to 0.
  - sram_OEN=0 throughout READ and DRAIN.
- READ, data capture:
  - inflight is set on an issue. The next cycle sram_DO for all banks is pushed into the FIFO as one row and inflight clears.
  - Rows leave in issue order. out_data is the FIFO head and stays stable while out_valid && !out_ready.
- Throughput and latency:
  - With out_ready held high, one row per cycle after a 2-cycle initial latency (issue -> capture -> out_valid).
  - No row is dropped or duplicated under any out_ready pattern.
- READ -> DRAIN when issued==row_count. DRAIN: CEN=1; wait until inflight=0 and the FIFO is empty.
- FINISH (one cycle):
  - done=1 and half_release=1; ping_pong_select toggles on the same edge.
  - busy=0 next cycle, then return to IDLE.
  - A start arriving in FINISH is ignored.
- half_loaded falling during READ is ignored; it is only sampled in WAIT_BUF.

Test Plan:
- Reset, then start base=0, count=4, half_loaded=1, out_ready=1 -> CEN low 4 consecutive cycles, A=0,1,2,3; out_valid rows 0..3 on consecutive cycles starting 2 cycles after the first issue; done pulse; ping_pong_select 0->1.
- Start base=126, count=4 -> A sequence 126,127,0,1; data order matches.
- count=8 with out_ready toggling 1,0,0,1,… -> 8 rows delivered in order, out_data held while stalled, no more than 2 rows outstanding (FIFO+inflight).
- half_loaded=0 for 5 cycles after start -> no CEN low, busy=1; reading begins the cycle after half_loaded rises.
- count=0 -> done pulse, no SRAM access, select unchanged; count=128 -> all 128 rows, last A=base-1 mod 128.
- rst asserted mid-READ after 3 of 10 rows -> all outputs at reset values next cycle, no done; a new start then runs cleanly from select=0.

Source files
------------

// File: rtl/input_sram_reader.sv
// rtl/input_sram_reader.sv - ping-pong input SRAM read controller streaming 8-bank rows to the PE array
module input_sram_reader #(
  parameter int NUM_BANKS  = 8,
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    base_addr,
  input  logic [ADDR_W:0]                      row_count,
  input  logic                                 half_loaded,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 half_release,
  output logic                                 ping_pong_select,
  output logic [NUM_BANKS-1:0][ADDR_W-1:0]     sram_A,
  output logic [NUM_BANKS-1:0]                 sram_CEN,
  output logic [NUM_BANKS-1:0]                 sram_OEN,
  output logic [NUM_BANKS-1:0]                 sram_WEN,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]     sram_DI,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]     sram_DO,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]     out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUF, S_READ, S_DRAIN, S_FINISH
  } state_t;

  localparam logic [2:0] LP_DEPTH = 3'(FIFO_DEPTH);

  state_t                              r_state;
  state_t                              w_next;
  logic [ADDR_W-1:0]                   r_base;
  logic [ADDR_W:0]                     r_count;
  logic [ADDR_W:0]                     r_issued;
  logic                                r_inflight;
  logic                                r_sel;
  logic                                r_zero_done;
  logic [1:0]                          r_fifo_cnt;
  logic                                r_rd_ptr;
  logic                                r_wr_ptr;
  logic [NUM_BANKS-1:0][DATA_W-1:0]    r_fifo [FIFO_DEPTH];

  logic                                w_issue;
  logic                                w_done;
  logic                                w_pop;
  logic                                w_rd_phase;
  logic                                w_accept;
  logic [2:0]                          w_occ;
  logic [ADDR_W-1:0]                   w_addr;

  // Rows held in the buffer plus the one coming out of the SRAM, net of this cycle's pop,
  // must stay below the buffer depth for a new read to be safe.
  assign out_valid  = !rst && (r_fifo_cnt != 2'd0);
  assign w_pop      = out_valid && out_ready;
  assign w_occ      = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_addr     = r_base + r_issued[ADDR_W-1:0];
  assign w_rd_phase = !rst && ((r_state == S_READ) || (r_state == S_DRAIN));
  assign w_accept   = (r_state == S_IDLE) && start;

  assign busy             = !rst && (r_state != S_IDLE);
  assign done             = w_done;
  assign half_release     = w_done;
  assign ping_pong_select = r_sel;
  assign out_data         = r_fifo[r_rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state, read issue and completion pulse; everything is forced idle while in reset.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_done  = r_zero_done;
    case (r_state)
      S_IDLE:     if (start && (row_count != '0)) w_next = S_WAIT_BUF;
      S_WAIT_BUF: if (half_loaded) w_next = S_READ;
      S_READ: begin
        if (r_issued == r_count) w_next = S_DRAIN;
        else if (w_occ < LP_DEPTH) w_issue = 1'b1;
      end
      S_DRAIN:    if (!r_inflight && (r_fifo_cnt == 2'd0)) w_next = S_FINISH;
      S_FINISH: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
    if (rst) begin
      w_issue = 1'b0;
      w_done  = 1'b0;
    end
  end

  // SRAM pins: one shared row address, enables active-low, write path parked.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      sram_A[i]   = w_issue ? w_addr : '0;
      sram_CEN[i] = ~w_issue;
      sram_OEN[i] = ~w_rd_phase;
      sram_WEN[i] = 1'b1;
      sram_DI[i]  = '0;
    end
  end

  // Pass bookkeeping: window latch, issue counter, in-flight flag, half selector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_inflight  <= 1'b0;
      r_sel       <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= w_accept && (row_count == '0);
      if (w_accept && (row_count != '0)) begin
        r_base   <= base_addr;
        r_count  <= row_count;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + 1'b1;
      end
      r_inflight <= w_issue;
      if (r_state == S_FINISH) r_sel <= ~r_sel;
    end
  end

  // Output buffer pointers and occupancy; a row lands the cycle after its read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_cnt <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      if (r_inflight) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Output buffer storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (!rst && r_inflight) r_fifo[r_wr_ptr] <= sram_DO;
  end

endmodule

// File: tb/tb_input_sram_reader.sv
// tb/tb_input_sram_reader.sv - directed vector bench for input_sram_reader
module tb_input_sram_reader;
  localparam int NB = 8;
  localparam int DW = 128;
  localparam int AW = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [AW-1:0]           base_addr;
  logic [AW:0]             row_count;
  logic                    half_loaded;
  logic                    busy, done, half_release, ping_pong_select;
  logic [NB-1:0][AW-1:0]   sram_A;
  logic [NB-1:0]           sram_CEN, sram_OEN, sram_WEN;
  logic [NB-1:0][DW-1:0]   sram_DI;
  logic [NB-1:0][DW-1:0]   sram_DO;
  logic [NB-1:0][DW-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;

  always #5 clk = ~clk;

  input_sram_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
    .half_loaded(half_loaded), .busy(busy), .done(done), .half_release(half_release),
    .ping_pong_select(ping_pong_select), .sram_A(sram_A), .sram_CEN(sram_CEN),
    .sram_OEN(sram_OEN), .sram_WEN(sram_WEN), .sram_DI(sram_DI), .sram_DO(sram_DO),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input int b, input logic s);
    logic [15:0] c;
    c = {4'hC, 3'(b), s, 1'b0, a};
    return {8{c}};
  endfunction

  function automatic logic [NB*DW-1:0] exp_row(input logic [AW-1:0] a, input logic s);
    logic [NB*DW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*DW +: DW] = pat(a, b, s);
    return r;
  endfunction

  // SRAM bank model: data for the sampled address appears the cycle after CEN low.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (!sram_CEN[b]) sram_DO[b] <= pat(sram_A[b], b, ping_pong_select);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int n_iss, n_rx, first_iss_cyc, last_iss_cyc, first_rx_cyc, last_rx_cyc;
  int max_out, done_cnt, hr_bad, bank_bad, stall_bad;
  logic [AW-1:0]     iss_q[$];
  logic [NB*DW-1:0]  rx_q[$];
  logic              prev_stall;
  logic [NB*DW-1:0]  prev_data;

  task automatic clr_mon();
    n_iss = 0; n_rx = 0; first_iss_cyc = -1; last_iss_cyc = -1;
    first_rx_cyc = -1; last_rx_cyc = -1; max_out = 0; done_cnt = 0;
    hr_bad = 0; bank_bad = 0; stall_bad = 0; prev_stall = 1'b0; prev_data = '0;
    iss_q.delete(); rx_q.delete();
  endtask

  initial begin
    clr_mon();
    forever begin
      @(negedge clk);
      if (n_iss - n_rx > max_out) max_out = n_iss - n_rx;
      if (sram_CEN != '0 && sram_CEN != '1) bank_bad++;
      if (!sram_CEN[0]) begin
        for (int b = 1; b < NB; b++) if (sram_A[b] != sram_A[0]) bank_bad++;
        if (n_iss == 0) first_iss_cyc = cyc;
        last_iss_cyc = cyc;
        iss_q.push_back(sram_A[0]);
        n_iss++;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (n_rx == 0) first_rx_cyc = cyc;
        last_rx_cyc = cyc;
        rx_q.push_back(out_data);
        n_rx++;
      end
      if (done) done_cnt++;
      if (done !== half_release) hr_bad++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"}, longint'(busy), 0);
    chk({p, "_done"}, longint'(done), 0);
    chk({p, "_half_release"}, longint'(half_release), 0);
    chk({p, "_out_valid"}, longint'(out_valid), 0);
    chk({p, "_select"}, longint'(ping_pong_select), 0);
    chk({p, "_cen"}, longint'(sram_CEN), 255);
    chk({p, "_oen"}, longint'(sram_OEN), 255);
    chk({p, "_wen"}, longint'(sram_WEN), 255);
    chk({p, "_addr"}, longint'(sram_A), 0);
    chk({p, "_di_zero"}, longint'(|sram_DI), 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            mode;
    int            hl;
    logic [AW-1:0] first_a;
    logic [AW-1:0] last_a;
    bit            span;
    logic          sel_after;
  } vec_t;

  function automatic logic rdy(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_pass(input vec_t v, input string tag);
    int s, wbad, bad;
    logic sel0;
    logic [AW-1:0] ea;
    sel0 = ~v.sel_after;
    @(posedge clk); #1;
    clr_mon();
    start = 1'b1; base_addr = v.base; row_count = v.cnt;
    half_loaded = (v.hl == 0); out_ready = rdy(v.mode, 0);
    s = cyc; wbad = 0;
    for (int k = 1; k < 1000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      half_loaded = (k > v.hl);
      out_ready = rdy(v.mode, k);
      if (k <= v.hl && !busy) wbad++;
      if (done_cnt > 0) break;
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_issues"}, n_iss, longint'(v.cnt));
    chk({tag, "_first_addr"}, (iss_q.size() > 0) ? longint'(iss_q[0]) : -1, longint'(v.first_a));
    chk({tag, "_last_addr"}, (iss_q.size() > 0) ? longint'(iss_q[iss_q.size()-1]) : -1,
        longint'(v.last_a));
    bad = 0;
    for (int j = 0; j < iss_q.size(); j++) begin
      ea = v.base + AW'(j);
      if (iss_q[j] != ea) bad++;
    end
    chk({tag, "_addr_seq_bad"}, bad, 0);
    chk({tag, "_rows"}, n_rx, longint'(v.cnt));
    bad = 0;
    for (int j = 0; j < rx_q.size(); j++) begin
      ea = v.base + AW'(j);
      if (rx_q[j] !== exp_row(ea, sel0)) bad++;
    end
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_first_issue_cycle"}, first_iss_cyc - s, v.hl + 2);
    if (v.span) begin
      chk({tag, "_latency"}, first_rx_cyc - first_iss_cyc, 2);
      chk({tag, "_rx_span"}, last_rx_cyc - first_rx_cyc, longint'(v.cnt) - 1);
      chk({tag, "_issue_span"}, last_iss_cyc - first_iss_cyc, longint'(v.cnt) - 1);
    end
    chk({tag, "_outstanding_le2"}, longint'(max_out <= 2), 1);
    chk({tag, "_stall_hold_bad"}, stall_bad, 0);
    chk({tag, "_bank_uniform_bad"}, bank_bad, 0);
    chk({tag, "_release_vs_done_bad"}, hr_bad, 0);
    chk({tag, "_wait_busy_bad"}, wbad, 0);
    chk({tag, "_select"}, longint'(ping_pong_select), longint'(v.sel_after));
    chk({tag, "_busy_after"}, longint'(busy), 0);
  endtask

  vec_t vt[6];
  vec_t vx;

  initial begin
    vt[0] = '{7'd0,   8'd4,   0, 0, 7'd0,   7'd3,   1'b1, 1'b1};
    vt[1] = '{7'd126, 8'd4,   0, 0, 7'd126, 7'd1,   1'b1, 1'b0};
    vt[2] = '{7'd10,  8'd8,   1, 0, 7'd10,  7'd17,  1'b0, 1'b1};
    vt[3] = '{7'd50,  8'd3,   0, 5, 7'd50,  7'd52,  1'b1, 1'b0};
    vt[4] = '{7'd5,   8'd128, 0, 0, 7'd5,   7'd4,   1'b1, 1'b1};
    vt[5] = '{7'd100, 8'd20,  2, 0, 7'd100, 7'd119, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0;
    half_loaded = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk_reset("reset");

    for (int i = 0; i < 6; i++) run_pass(vt[i], $sformatf("vec%0d", i));

    // Zero-length command: completion pulse only, no SRAM activity, selector kept.
    @(posedge clk); #1;
    clr_mon();
    start = 1'b1; base_addr = 7'd33; row_count = 8'd0; half_loaded = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; #1;
    chk("zero_done", longint'(done), 1);
    chk("zero_half_release", longint'(half_release), 1);
    chk("zero_busy", longint'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_issues", n_iss, 0);
    chk("zero_done_pulses", done_cnt, 1);
    chk("zero_select", longint'(ping_pong_select), 0);

    vx = '{7'd7, 8'd2, 0, 0, 7'd7, 7'd8, 1'b1, 1'b1};
    run_pass(vx, "pre_reset");

    // Abort a pass with reset after three rows have been issued.
    @(posedge clk); #1;
    clr_mon();
    start = 1'b1; base_addr = 7'd20; row_count = 8'd10; half_loaded = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n_iss >= 3) break;
    end
    chk("abort_issued_before_reset", n_iss, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk_reset("abort");
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_more_issues", n_iss, 3);

    vx = '{7'd40, 8'd5, 0, 0, 7'd40, 7'd44, 1'b1, 1'b1};
    run_pass(vx, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
